// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, waits WAIT_STATES
// cycles, then commits the store or returns load data with a one-cycle pulse.
module dmem_responder #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             stall,
  output logic             busy,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [WIDTH:0]  LIMIT    = (WIDTH + 1)'(DEPTH * 4);
  localparam logic [CW-1:0]   CNT_INIT = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT            state, stateNext;
  logic [CW-1:0]    cnt, cntNext;
  logic             capWe;
  logic [WIDTH-1:0] capAddr, capWdata;

  logic             opWe, opErr, enterResp;
  logic [WIDTH-1:0] opAddr, opWdata;
  logic [AW-1:0]    opIdx;

  logic [WIDTH-1:0] mem [DEPTH];

  // With zero wait states RESP is entered straight from IDLE, so the live
  // request fields are used instead of the not-yet-captured registers.
  always_comb begin
    opWe    = (state == IDLE) ? req_we    : capWe;
    opAddr  = (state == IDLE) ? req_addr  : capAddr;
    opWdata = (state == IDLE) ? req_wdata : capWdata;
    opIdx   = opAddr[2 +: AW];
    opErr   = (opAddr[1:0] != 2'b00) || ({1'b0, opAddr} >= LIMIT);
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    enterResp = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            stateNext = RESP;
            enterResp = 1'b1;
          end else begin
            stateNext = WAIT;
            cntNext   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          stateNext = RESP;
          enterResp = 1'b1;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      capWe     <= 1'b0;
      capAddr   <= '0;
      capWdata  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (state == IDLE && req_valid) begin
        capWe    <= req_we;
        capAddr  <= req_addr;
        capWdata <= req_wdata;
      end
      if (enterResp) begin
        rsp_err   <= opErr;
        rsp_rdata <= (!opErr && !opWe) ? mem[opIdx] : '0;
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (enterResp && !reset && opWe && !opErr)
      mem[opIdx] <= opWdata;
  end

  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign stall     = req_valid & ~rsp_valid;

endmodule
